// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and types for the CDB writeback arbiter.
//   CDB_SRC_ALU / CDB_SRC_LSB : values carried on cdb_src
//   DATA_W                    : width of result values and branch targets
//   cdb_src_e                 : producer identity, also used for last_grant
package cdb_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // The producer that did not win last time; used to settle ties.
  function automatic cdb_src_e other_src(input cdb_src_e src);
    return (src == SRC_ALU) ? SRC_LSB : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshakes and CDB broadcast bundle.
//   alu_* : ALU/RS result offer (valid/ready, rob index, value, branch info)
//   lsb_* : LSB completion offer (valid/ready, rob index, load data)
//   cdb_* : registered broadcast towards ROB and RS/LSB wake-up
// master = producers/consumers side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4
);
  import cdb_arbiter_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [ROB_WIDTH-1:0] alu_rob_idx;
  logic [DATA_W-1:0]    alu_val;
  logic                 alu_br_taken;
  logic [DATA_W-1:0]    alu_br_target;

  logic                 lsb_valid;
  logic                 lsb_ready;
  logic [ROB_WIDTH-1:0] lsb_rob_idx;
  logic [DATA_W-1:0]    lsb_val;

  logic                 cdb_valid;
  logic                 cdb_src;
  logic [ROB_WIDTH-1:0] cdb_rob_idx;
  logic [DATA_W-1:0]    cdb_val;
  logic                 cdb_br_taken;
  logic [DATA_W-1:0]    cdb_br_target;

  modport master (
    output alu_valid, alu_rob_idx, alu_val, alu_br_taken, alu_br_target,
    output lsb_valid, lsb_rob_idx, lsb_val,
    input  alu_ready, lsb_ready,
    input  cdb_valid, cdb_src, cdb_rob_idx, cdb_val, cdb_br_taken, cdb_br_target
  );

  modport slave (
    input  alu_valid, alu_rob_idx, alu_val, alu_br_taken, alu_br_target,
    input  lsb_valid, lsb_rob_idx, lsb_val,
    output alu_ready, lsb_ready,
    output cdb_valid, cdb_src, cdb_rob_idx, cdb_val, cdb_br_taken, cdb_br_target
  );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// cdb_src_fifo: small per-producer result queue.
//   clk_in, rst_in (sync, active-low), rdy_in (freeze), clr_in (flush)
//   push/din : write din at the tail
//   pop      : advance the head
//   head     : current head entry (valid when !empty)
//   full, empty : derived from the registered count
module cdb_src_fifo #(
  parameter int WIDTH  = 8,
  parameter int QDEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == {CW{1'b0}});
  assign head  = mem[rd_ptr];

  // Guard against misuse so the count can never leave 0..QDEPTH.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy tracking; pointers wrap naturally (QDEPTH is 2^n).
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (clr_in) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (rdy_in) begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents need no reset since empty entries are never read out.
  always_ff @(posedge clk_in) begin
    if (rst_in && !clr_in && rdy_in && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single CDB writeback port between the ALU/RS
// result path and the LSB completion path.
//   clk_in  : clock
//   rst_in  : synchronous active-low reset
//   rdy_in  : global enable; low freezes all state
//   clr_in  : misprediction flush, drops everything in flight
//   bus     : cdb_arbiter_if.slave (producer handshakes + registered CDB)
// Each producer has a QDEPTH queue; one result per cycle is popped by
// round-robin into the registered cdb_* outputs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH = 4,
  parameter int QDEPTH    = 2
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          clr_in,
  cdb_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ROB_WIDTH-1:0] rob_idx;
    logic [DATA_W-1:0]    val;
    logic                 br_taken;
    logic [DATA_W-1:0]    br_target;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t alu_in, lsb_in, alu_head, lsb_head, sel_head;
  logic     alu_full, alu_empty, lsb_full, lsb_empty;
  logic     alu_ready_i, lsb_ready_i;
  logic     alu_push, lsb_push, alu_pop, lsb_pop;
  logic     advance, tie, grant_valid;
  cdb_src_e grant_src, last_grant;

  logic                 cdb_valid_q;
  cdb_src_e             cdb_src_q;
  logic [ROB_WIDTH-1:0] cdb_rob_idx_q;
  logic [DATA_W-1:0]    cdb_val_q;
  logic                 cdb_br_taken_q;
  logic [DATA_W-1:0]    cdb_br_target_q;

  // Load/store completions carry no branch information.
  assign alu_in = '{bus.alu_rob_idx, bus.alu_val, bus.alu_br_taken, bus.alu_br_target};
  assign lsb_in = '{bus.lsb_rob_idx, bus.lsb_val, 1'b0, {DATA_W{1'b0}}};

  // Readiness uses registered occupancy only: a full queue refuses even
  // if it is being popped in the same cycle.
  assign advance     = rdy_in & ~clr_in;
  assign alu_ready_i = advance & ~alu_full;
  assign lsb_ready_i = advance & ~lsb_full;
  assign alu_push    = bus.alu_valid & alu_ready_i;
  assign lsb_push    = bus.lsb_valid & lsb_ready_i;

  assign bus.alu_ready = alu_ready_i;
  assign bus.lsb_ready = lsb_ready_i;

  cdb_src_fifo #(.WIDTH(PW), .QDEPTH(QDEPTH)) u_alu_q (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clr_in (clr_in),
    .push   (alu_push),
    .din    (alu_in),
    .pop    (alu_pop),
    .head   (alu_head),
    .full   (alu_full),
    .empty  (alu_empty)
  );

  cdb_src_fifo #(.WIDTH(PW), .QDEPTH(QDEPTH)) u_lsb_q (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clr_in (clr_in),
    .push   (lsb_push),
    .din    (lsb_in),
    .pop    (lsb_pop),
    .head   (lsb_head),
    .full   (lsb_full),
    .empty  (lsb_empty)
  );

  // Grant selection: a lone non-empty queue wins outright; on a tie the
  // producer other than last_grant wins.
  always_comb begin
    tie         = 1'b0;
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    if (!alu_empty && !lsb_empty) begin
      tie         = 1'b1;
      grant_valid = 1'b1;
      grant_src   = other_src(last_grant);
    end else if (!alu_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_ALU;
    end else if (!lsb_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_LSB;
    end else begin
      grant_valid = 1'b0;
      grant_src   = SRC_ALU;
    end
  end

  assign alu_pop  = advance & grant_valid & (grant_src == SRC_ALU);
  assign lsb_pop  = advance & grant_valid & (grant_src == SRC_LSB);
  assign sel_head = (grant_src == SRC_LSB) ? lsb_head : alu_head;

  // Broadcast registers and round-robin pointer; last_grant starts at LSB
  // so the ALU wins the first tie.
  always_ff @(posedge clk_in) begin
    if (!rst_in || clr_in) begin
      cdb_valid_q     <= 1'b0;
      cdb_src_q       <= SRC_ALU;
      cdb_rob_idx_q   <= {ROB_WIDTH{1'b0}};
      cdb_val_q       <= {DATA_W{1'b0}};
      cdb_br_taken_q  <= 1'b0;
      cdb_br_target_q <= {DATA_W{1'b0}};
      last_grant      <= SRC_LSB;
    end else if (rdy_in) begin
      if (grant_valid) begin
        cdb_valid_q     <= 1'b1;
        cdb_src_q       <= grant_src;
        cdb_rob_idx_q   <= sel_head.rob_idx;
        cdb_val_q       <= sel_head.val;
        cdb_br_taken_q  <= sel_head.br_taken;
        cdb_br_target_q <= sel_head.br_target;
        if (tie) last_grant <= grant_src;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.cdb_rob_idx   = cdb_rob_idx_q;
  assign bus.cdb_val       = cdb_val_q;
  assign bus.cdb_br_taken  = cdb_br_taken_q;
  assign bus.cdb_br_target = cdb_br_target_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter. A queue-level model
// predicts readiness and the sequence of broadcasts; a separate monitor
// compares every consumed CDB beat against the expected queue.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int ROB_WIDTH = 4;
  localparam int QDEPTH    = 2;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr_in;

  cdb_arbiter_if #(.ROB_WIDTH(ROB_WIDTH)) bus ();

  cdb_arbiter #(.ROB_WIDTH(ROB_WIDTH), .QDEPTH(QDEPTH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clr_in (clr_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        src;
    logic [3:0]  idx;
    logic [31:0] val;
    logic        tk;
    logic [31:0] tgt;
  } res_t;

  res_t alu_mq[$];
  res_t lsb_mq[$];
  res_t exp_q[$];
  logic last_grant_m;
  logic [3:0] log_idx[$];
  logic       log_src[$];
  bit   mon_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check readiness against the
  // model, advance the model, and publish the predicted broadcast after the edge.
  task automatic cycle(input logic rdy, input logic clr,
                       input logic av, input logic [3:0] aidx, input logic [31:0] aval,
                       input logic atk, input logic [31:0] atgt,
                       input logic lv, input logic [3:0] lidx, input logic [31:0] lval,
                       output logic a_acc, output logic l_acc);
    res_t popped;
    logic have_pop, exp_ar, exp_lr;
    @(negedge clk_in);
    rdy_in = rdy; clr_in = clr;
    bus.alu_valid = av; bus.alu_rob_idx = aidx; bus.alu_val = aval;
    bus.alu_br_taken = atk; bus.alu_br_target = atgt;
    bus.lsb_valid = lv; bus.lsb_rob_idx = lidx; bus.lsb_val = lval;
    #1;
    exp_ar = rdy && !clr && (alu_mq.size() < QDEPTH);
    exp_lr = rdy && !clr && (lsb_mq.size() < QDEPTH);
    check("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
    check("lsb_ready", 32'(bus.lsb_ready), 32'(exp_lr));
    a_acc = av && exp_ar;
    l_acc = lv && exp_lr;
    have_pop = 1'b0;
    popped = '0;
    if (clr) begin
      alu_mq.delete(); lsb_mq.delete(); exp_q.delete();
      last_grant_m = 1'b1;
    end else if (rdy) begin
      if (alu_mq.size() > 0 && lsb_mq.size() > 0) begin
        popped = last_grant_m ? alu_mq.pop_front() : lsb_mq.pop_front();
        last_grant_m = popped.src;
        have_pop = 1'b1;
      end else if (alu_mq.size() > 0) begin
        popped = alu_mq.pop_front(); have_pop = 1'b1;
      end else if (lsb_mq.size() > 0) begin
        popped = lsb_mq.pop_front(); have_pop = 1'b1;
      end
      if (a_acc) alu_mq.push_back('{1'b0, aidx, aval, atk, atgt});
      if (l_acc) lsb_mq.push_back('{1'b1, lidx, lval, 1'b0, 32'h0});
    end
    @(posedge clk_in);
    #1;
    if (have_pop) exp_q.push_back(popped);
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, a, l);
  endtask

  // Monitor: a beat is consumed at an edge where rdy_in=1 and clr_in=0.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk_in);
      #2;
      if (mon_en && !clr_in) begin
        check("cdb_valid", 32'(bus.cdb_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          check("cdb_src", 32'(bus.cdb_src), 32'(e.src));
          check("cdb_rob_idx", 32'(bus.cdb_rob_idx), 32'(e.idx));
          check("cdb_val", bus.cdb_val, e.val);
          check("cdb_br_taken", 32'(bus.cdb_br_taken), 32'(e.tk));
          check("cdb_br_target", bus.cdb_br_target, e.tgt);
          if (rdy_in) begin
            void'(exp_q.pop_front());
            log_idx.push_back(bus.cdb_rob_idx);
            log_src.push_back(bus.cdb_src);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic a_acc, l_acc;
    logic a_pend, l_pend;
    logic [3:0] aidx, lidx;
    logic [31:0] aval, atgt, lval;
    logic atk;
    logic [3:0] tie_idx[4];
    logic       tie_src[4];
    logic [3:0] bp_idx[3];
    int n_lsb, n7, a_n, l_sent;

    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rob_idx = 4'd0; bus.alu_val = 32'd0;
    bus.alu_br_taken = 1'b0; bus.alu_br_target = 32'd0;
    bus.lsb_valid = 1'b0; bus.lsb_rob_idx = 4'd0; bus.lsb_val = 32'd0;
    last_grant_m = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst_lsb_ready", 32'(bus.lsb_ready), 32'd1);
    check("rst_cdb_src", 32'(bus.cdb_src), 32'd0);
    check("rst_cdb_rob_idx", 32'(bus.cdb_rob_idx), 32'd0);
    check("rst_cdb_val", bus.cdb_val, 32'd0);
    check("rst_cdb_br_taken", 32'(bus.cdb_br_taken), 32'd0);
    check("rst_cdb_br_target", bus.cdb_br_target, 32'd0);
    mon_en = 1'b1;

    // Single ALU result.
    log_idx.delete(); log_src.delete();
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 32'h1234, 1'b1, 32'h80, 1'b0, 4'd0, 32'd0, a_acc, l_acc);
    idle(3);
    check("single_count", 32'(log_idx.size()), 32'd1);

    // Tie round-robin.
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, a_acc, l_acc);
    log_idx.delete(); log_src.delete();
    cycle(1'b1, 1'b0, 1'b1, 4'd1, 32'h11, 1'b0, 32'h0, 1'b1, 4'd5, 32'h55, a_acc, l_acc);
    cycle(1'b1, 1'b0, 1'b1, 4'd2, 32'h22, 1'b1, 32'h40, 1'b1, 4'd6, 32'h66, a_acc, l_acc);
    idle(6);
    tie_idx[0] = 4'd1; tie_idx[1] = 4'd5; tie_idx[2] = 4'd2; tie_idx[3] = 4'd6;
    tie_src[0] = 1'b0; tie_src[1] = 1'b1; tie_src[2] = 1'b0; tie_src[3] = 1'b1;
    check("tie_count", 32'(log_idx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_idx.size()) begin
        check("tie_order_idx", 32'(log_idx[i]), 32'(tie_idx[i]));
        check("tie_order_src", 32'(log_src[i]), 32'(tie_src[i]));
      end
    end

    // Backpressure: LSB offers 3 held results against continuous ALU traffic.
    log_idx.delete(); log_src.delete();
    a_n = 0; l_sent = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 4'(a_n), 32'(a_n), 1'b0, 32'd0,
            (l_sent < 3), 4'(9 + l_sent), 32'(100 + l_sent), a_acc, l_acc);
      if (a_acc) a_n++;
      if (l_acc) l_sent++;
    end
    idle(8);
    bp_idx[0] = 4'd9; bp_idx[1] = 4'd10; bp_idx[2] = 4'd11;
    n_lsb = 0;
    for (int i = 0; i < log_idx.size(); i++) begin
      if (log_src[i] == 1'b1) begin
        if (n_lsb < 3) check("bp_lsb_order", 32'(log_idx[i]), 32'(bp_idx[n_lsb]));
        n_lsb++;
      end
    end
    check("bp_lsb_count", 32'(n_lsb), 32'd3);

    // Flush with both queues loaded and a broadcast on the bus.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 1'b1, 4'(i), 32'(i), 1'b1, 32'(i), 1'b1, 4'(8 + i), 32'(i), a_acc, l_acc);
    cycle(1'b1, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'd0, a_acc, l_acc);
    log_idx.delete(); log_src.delete();
    idle(5);
    check("flush_no_bcast", 32'(log_idx.size()), 32'd0);

    // Stall with idx 7 queued while ALU keeps offering.
    log_idx.delete(); log_src.delete();
    cycle(1'b1, 1'b0, 1'b1, 4'd7, 32'h77, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, a_acc, l_acc);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, 4'd8, 32'h88, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, a_acc, l_acc);
    cycle(1'b1, 1'b0, 1'b1, 4'd8, 32'h88, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, a_acc, l_acc);
    idle(4);
    n7 = 0;
    for (int i = 0; i < log_idx.size(); i++) if (log_idx[i] == 4'd7) n7++;
    check("stall_idx7_once", 32'(n7), 32'd1);

    // Randomised traffic with held payloads, stalls and flushes.
    a_pend = 1'b0; l_pend = 1'b0;
    aidx = 4'd0; aval = 32'd0; atk = 1'b0; atgt = 32'd0; lidx = 4'd0; lval = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      if (!a_pend && ($urandom_range(0, 3) != 0)) begin
        a_pend = 1'b1; aidx = 4'($urandom_range(0, 15)); aval = $urandom;
        atk = 1'($urandom_range(0, 1)); atgt = $urandom;
      end
      if (!l_pend && ($urandom_range(0, 2) != 0)) begin
        l_pend = 1'b1; lidx = 4'($urandom_range(0, 15)); lval = $urandom;
      end
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
            a_pend, aidx, aval, atk, atgt, l_pend, lidx, lval, a_acc, l_acc);
      if (a_acc) a_pend = 1'b0;
      if (l_acc) l_pend = 1'b0;
    end
    idle(6);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
